tlb_array: RTL
==============

Name: tlb_array

Overview:
- Fully associative joint TLB. It is the responder for the TLB write, read and search ports driven by the write-back stage and CP0 logic.
- Holds TLBNUM entries. Each entry maps an even/odd virtual page pair (VPN2) plus ASID to two physical frames.
- Serves two concurrent lookup ports: port 0 for instruction fetch, port 1 for data and TLBP.
- Accepts one TLBWI-style write per cycle and one TLBR-style indexed read.

Parameters:
- TLBNUM, 16, number of entries; must satisfy TLBNUM <= 2**IDX_W.
- IDX_W, 4, width of all index ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s0_vpn2  in  19  port 0 search VPN2 (VA[31:13])
- s0_odd_page  in  1  port 0 page select (VA[12])
- s0_asid  in  8  port 0 search ASID
- s0_found  out  1  port 0 hit
- s0_index  out  IDX_W  port 0 hit index
- s0_pfn  out  20  port 0 selected PFN
- s0_c  out  3  port 0 selected cache attribute
- s0_d  out  1  port 0 selected dirty bit
- s0_v  out  1  port 0 selected valid bit
- s0_multi  out  1  port 0 multiple-hit flag (see Optional Feature)
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi: same as port 0, for port 1
- we  in  1  write enable
- w_index  in  IDX_W  write index
- w_vpn2  in  19  write VPN2
- w_asid  in  8  write ASID
- w_g  in  1  write global bit
- w_pfn0  in  20  write even-page PFN
- w_c0  in  3  write even-page C
- w_d0  in  1  write even-page D
- w_v0  in  1  write even-page V
- w_pfn1  in  20  write odd-page PFN
- w_c1  in  3  write odd-page C
- w_d1  in  1  write odd-page D
- w_v1  in  1  write odd-page V
- inv_all  in  1  clear all entry-present bits
- r_index  in  IDX_W  read index
- r_vpn2  out  19  entry VPN2 at r_index
- r_asid  out  8  entry ASID at r_index
- r_g  out  1  entry G at r_index
- r_pfn0  out  20  entry even PFN
- r_c0  out  3  entry even C
- r_d0  out  1  entry even D
- r_v0  out  1  entry even V
- r_pfn1  out  20  entry odd PFN
- r_c1  out  3  entry odd C
- r_d1  out  1  entry odd D
- r_v1  out  1  entry odd V

Behaviour:
- Storage: per-entry registers vpn2, asid, g, pfn0/c0/d0/v0, pfn1/c1/d1/v1, plus a hidden present bit e[i].
- Reset: all fields and all e[i] become 0. All search outputs are therefore 0, and r_* read 0 for every index in the cycle after reset.
- Write: when we=1 at a rising edge, entry w_index takes all w_* fields and e[w_index] becomes 1. No effect if w_index >= TLBNUM.
- inv_all=1 at an edge clears every e[i]; data fields are kept.
- inv_all and we in the same cycle: all e[] are cleared first, then the write sets e[w_index]=1. The written entry survives.
- Match condition for entry i on port k: e[i] && vpn2[i]==sk_vpn2 && (g[i] || asid[i]==sk_asid).
- sk_found = OR of all matches for port k.
- sk_index = lowest matching index; 0 when there is no hit.
- Selected fields: sk_odd_page=0 gives pfn0/c0/d0/v0 of the hit entry; sk_odd_page=1 gives pfn1/c1/d1/v1.
- On a miss, sk_pfn, sk_c, sk_d and sk_v are all 0.
- Search latency: combinational on the current array contents. A write in cycle N is visible to searches and reads from cycle N+1. In cycle N itself, searches see the old contents (no write bypass).
- Both search ports are fully independent and may hit the same entry in the same cycle.
- Read: r_* is combinational from entry r_index, including entries with e=0. If r_index >= TLBNUM, all r_* outputs are 0.
- The found bit ignores V. Invalid and refill exceptions are decided by the requester from sk_found and sk_v.

Optional Feature:
- Macro: TLB_MULTIHIT_DET_EN.
- Defined: sk_multi=1 when two or more entries match on port k in that cycle (population count > 1). sk_index/sk_pfn still report the lowest matching index.
- Undefined: s0_multi and s1_multi are tied to 0 and the match-count logic is omitted. Ports are present in both builds.

Test Plan:
- Reset, then search s0 with vpn2=0, asid=0, odd=0 -> s0_found=0, all s0 fields 0; r_index=3 -> all r_* 0.
- Write idx 5 (vpn2=0x12345, asid=0x2A, g=0, pfn0=0xABCDE, c0=3, d0=1, v0=1, pfn1=0x11111, v1=0). Next cycle, s1 search vpn2=0x12345, asid=0x2A, odd=1 -> found=1, index=5, pfn=0x11111, v=0. Same search with asid=0x2B -> found=0.
- Write idx 7 with g=1, vpn2=0x00400. Search asid=0xFF, odd=0 on both ports in the same cycle -> both found=1, index=7.
- Write idx 2 and search the same VPN2 in the same cycle -> found=0 that cycle, found=1, index=2 the next cycle. r_index=2 shows the new data only after the edge.
- Entries 1 and 9 with identical vpn2/asid; search -> index=1. With TLB_MULTIHIT_DET_EN, multi=1; without it, multi=0.
- inv_all together with we to idx 4 -> afterwards only idx 4 hits. A previous idx 5 mapping misses, while r_index=5 still returns its stored data.

Source files
------------

// File: rtl/tlb_array.sv
// Fully associative joint TLB, two search ports; TLB_MULTIHIT_DET_EN adds multi-hit flags.
// Searches/reads combinational on current contents, writes land at the edge; no backpressure.
module tlb_array #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [18:0]      s0_vpn2,
    input  logic             s0_odd_page,
    input  logic [7:0]       s0_asid,
    output logic             s0_found,
    output logic [IDX_W-1:0] s0_index,
    output logic [19:0]      s0_pfn,
    output logic [2:0]       s0_c,
    output logic             s0_d,
    output logic             s0_v,
    output logic             s0_multi,

    input  logic [18:0]      s1_vpn2,
    input  logic             s1_odd_page,
    input  logic [7:0]       s1_asid,
    output logic             s1_found,
    output logic [IDX_W-1:0] s1_index,
    output logic [19:0]      s1_pfn,
    output logic [2:0]       s1_c,
    output logic             s1_d,
    output logic             s1_v,
    output logic             s1_multi,

    input  logic             we,
    input  logic [IDX_W-1:0] w_index,
    input  logic [18:0]      w_vpn2,
    input  logic [7:0]       w_asid,
    input  logic             w_g,
    input  logic [19:0]      w_pfn0,
    input  logic [2:0]       w_c0,
    input  logic             w_d0,
    input  logic             w_v0,
    input  logic [19:0]      w_pfn1,
    input  logic [2:0]       w_c1,
    input  logic             w_d1,
    input  logic             w_v1,
    input  logic             inv_all,

    input  logic [IDX_W-1:0] r_index,
    output logic [18:0]      r_vpn2,
    output logic [7:0]       r_asid,
    output logic             r_g,
    output logic [19:0]      r_pfn0,
    output logic [2:0]       r_c0,
    output logic             r_d0,
    output logic             r_v0,
    output logic [19:0]      r_pfn1,
    output logic [2:0]       r_c1,
    output logic             r_d1,
    output logic             r_v1
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
        logic [19:0]      pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
        logic             multi;
    } srch_res_t;

    tlb_entry_t        ent_q [TLBNUM];
    logic [TLBNUM-1:0] e_q, e_d;
    tlb_entry_t        w_ent;
    tlb_entry_t        rd_ent;

    logic [18:0]       s_vpn2 [2];
    logic              s_odd  [2];
    logic [7:0]        s_asid [2];
    logic [TLBNUM-1:0] match  [2];
    srch_res_t         res    [2];

    assign w_ent = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

    // Invalidate-all applies before the write so a same-cycle write survives.
    always_comb begin
        e_d = e_q;
        if (inv_all) e_d = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (we && w_index == IDX_W'(i)) e_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            for (int i = 0; i < TLBNUM; i++) ent_q[i] <= '0;
        end else begin
            e_q <= e_d;
            for (int i = 0; i < TLBNUM; i++) begin
                if (we && w_index == IDX_W'(i)) ent_q[i] <= w_ent;
            end
        end
    end

    assign s_vpn2[0] = s0_vpn2;
    assign s_vpn2[1] = s1_vpn2;
    assign s_odd[0]  = s0_odd_page;
    assign s_odd[1]  = s1_odd_page;
    assign s_asid[0] = s0_asid;
    assign s_asid[1] = s1_asid;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < TLBNUM; i++) begin
                match[p][i] = e_q[i] && (ent_q[i].vpn2 == s_vpn2[p]) &&
                              (ent_q[i].g || (ent_q[i].asid == s_asid[p]));
            end
        end
    end

    // Descending scan so the lowest matching entry wins the select.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            tlb_entry_t sel;
            sel          = '0;
            res[p]       = '0;
            res[p].found = |match[p];
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (match[p][i]) begin
                    res[p].index = IDX_W'(i);
                    sel          = ent_q[i];
                end
            end
            res[p].pfn = s_odd[p] ? sel.pfn1 : sel.pfn0;
            res[p].c   = s_odd[p] ? sel.c1   : sel.c0;
            res[p].d   = s_odd[p] ? sel.d1   : sel.d0;
            res[p].v   = s_odd[p] ? sel.v1   : sel.v0;
`ifdef TLB_MULTIHIT_DET_EN
            res[p].multi = |(match[p] & (match[p] - TLBNUM'(1)));
`else
            res[p].multi = 1'b0;
`endif
        end
    end

    assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_multi} = res[0];
    assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi} = res[1];

    // Out-of-range indices match no entry and therefore read as zero.
    always_comb begin
        rd_ent = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (r_index == IDX_W'(i)) rd_ent = ent_q[i];
        end
    end

    assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
            r_pfn1, r_c1, r_d1, r_v1} = rd_ent;

endmodule
